// File: rtl/word_to_byte_streamer_pkg.sv
// Shared constants and state encoding for the word-to-byte AXI4-Stream down-converter.
package w2b_pkg;

  localparam int WORD_BYTES_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 32;
  localparam int PKT_CNT_WIDTH  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } w2b_state_e;

endpackage

// File: rtl/word_to_byte_streamer_lane_select.sv
// Picks the next lane to emit from a byte-valid mask: lowest set bit (little endian)
// or highest set bit (big endian), plus a flag for "exactly one lane left".
module byte_lane_select #(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic [WORD_BYTES-1:0] mask,
  output logic [WORD_BYTES-1:0] lane_onehot,
  output logic [IDX_W-1:0]      lane_idx,
  output logic                  single_bit
);

  // Scan position i maps to lane i (LE) or to the mirrored lane (BE).
  function automatic int lane_of(input int i);
    return BIG_ENDIAN ? (WORD_BYTES - 1 - i) : i;
  endfunction

  logic found;

  // NOTE: every output gets a default before the loop, otherwise a mask of zero
  // would leave them unassigned and infer latches.
  always_comb begin
    lane_onehot = '0;
    lane_idx    = '0;
    found       = 1'b0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (!found && mask[lane_of(i)]) begin
        found                = 1'b1;
        lane_onehot[lane_of(i)] = 1'b1;
        lane_idx             = IDX_W'(lane_of(i));
      end
    end
  end

  assign single_bit = (mask != '0) && ((mask & (mask - WORD_BYTES'(1))) == '0);

endmodule

// File: rtl/word_to_byte_streamer.sv
// AXI4-Stream width down-converter: 8*WORD_BYTES-bit words with TKEEP/TLAST in,
// one byte per beat out. Null lanes are skipped; byte/packet counters for status.
module word_to_byte_streamer
  import w2b_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [8*WORD_BYTES-1:0]  s_axis_tdata,
  input  logic [WORD_BYTES-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CNT_WIDTH-1:0]     byte_count,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     null_last_err
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  w2b_state_e                 state_q,      state_d;
  logic [8*WORD_BYTES-1:0]    hold_data_q,  hold_data_d;
  logic [WORD_BYTES-1:0]      rem_mask_q,   rem_mask_d;
  logic                       hold_last_q,  hold_last_d;
  logic [CNT_WIDTH-1:0]       byte_count_q, byte_count_d;
  logic [PKT_CNT_WIDTH-1:0]   pkt_count_q,  pkt_count_d;
  logic                       null_err_q,   null_err_d;

  logic [WORD_BYTES-1:0] lane_onehot;
  logic [IDX_W-1:0]      lane_idx;
  logic                  single_bit;
  logic                  byte_hs;
  logic                  word_acc;

  byte_lane_select #(
    .WORD_BYTES (WORD_BYTES),
    .BIG_ENDIAN (BIG_ENDIAN != 0)
  ) u_lane_select (
    .mask        (rem_mask_q),
    .lane_onehot (lane_onehot),
    .lane_idx    (lane_idx),
    .single_bit  (single_bit)
  );

  // Outputs come only from the holding registers, never straight from s_axis.
  assign m_axis_tvalid = (state_q == ST_DRAIN);
  assign m_axis_tdata  = hold_data_q[8*int'(lane_idx) +: 8];
  assign m_axis_tlast  = hold_last_q & single_bit;

  // Taking the next word while the final byte leaves keeps the byte stream gap-free.
  assign s_axis_tready = !ARESET && ((state_q == ST_EMPTY) || (m_axis_tready && single_bit));

  assign byte_hs  = m_axis_tvalid & m_axis_tready;
  assign word_acc = s_axis_tvalid & s_axis_tready;

  always_comb begin
    hold_data_d  = hold_data_q;
    rem_mask_d   = rem_mask_q;
    hold_last_d  = hold_last_q;
    byte_count_d = byte_count_q;
    pkt_count_d  = pkt_count_q;
    null_err_d   = null_err_q;

    if (byte_hs) begin
      rem_mask_d   = rem_mask_q & ~lane_onehot;
      byte_count_d = byte_count_q + CNT_WIDTH'(1);
      if (m_axis_tlast) pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
    end

    // A loaded word overrides the lane clear above; a null word leaves state alone.
    if (word_acc) begin
      if (s_axis_tkeep != '0) begin
        hold_data_d = s_axis_tdata;
        rem_mask_d  = s_axis_tkeep;
        hold_last_d = s_axis_tlast;
      end else if (s_axis_tlast) begin
        null_err_d = 1'b1;
      end
    end

    state_d = (rem_mask_d != '0) ? ST_DRAIN : ST_EMPTY;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed in the combinational block.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_EMPTY;
      hold_data_q  <= '0;
      rem_mask_q   <= '0;
      hold_last_q  <= 1'b0;
      byte_count_q <= '0;
      pkt_count_q  <= '0;
      null_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      rem_mask_q   <= rem_mask_d;
      hold_last_q  <= hold_last_d;
      byte_count_q <= byte_count_d;
      pkt_count_q  <= pkt_count_d;
      null_err_q   <= null_err_d;
    end
  end

  assign byte_count    = byte_count_q;
  assign pkt_count     = pkt_count_q;
  assign null_last_err = null_err_q;

endmodule

// File: tb/tb_word_to_byte_streamer.sv
// Randomized and directed bench for word_to_byte_streamer against a byte-queue model.
module tb_word_to_byte_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;

  // Little-endian instance, narrow byte counter so wrap-around is exercised.
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
  logic [7:0]  byte_count;
  logic [15:0] pkt_count;
  logic        null_err;

  // Big-endian instance with default counter width.
  logic [31:0] be_s_tdata;
  logic [3:0]  be_s_tkeep;
  logic        be_s_tlast, be_s_tvalid, be_s_tready;
  logic [7:0]  be_m_tdata;
  logic        be_m_tlast, be_m_tvalid, be_m_tready;
  logic [31:0] be_byte_count;
  logic [15:0] be_pkt_count;
  logic        be_null_err;

  word_to_byte_streamer #(.WORD_BYTES(4), .BIG_ENDIAN(0), .CNT_WIDTH(8)) dut (
    .ACLK(clk), .ARESET(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .byte_count(byte_count), .pkt_count(pkt_count), .null_last_err(null_err)
  );

  word_to_byte_streamer #(.WORD_BYTES(4), .BIG_ENDIAN(1), .CNT_WIDTH(32)) dut_be (
    .ACLK(clk), .ARESET(areset),
    .s_axis_tdata(be_s_tdata), .s_axis_tkeep(be_s_tkeep), .s_axis_tlast(be_s_tlast),
    .s_axis_tvalid(be_s_tvalid), .s_axis_tready(be_s_tready),
    .m_axis_tdata(be_m_tdata), .m_axis_tlast(be_m_tlast), .m_axis_tvalid(be_m_tvalid),
    .m_axis_tready(be_m_tready),
    .byte_count(be_byte_count), .pkt_count(be_pkt_count), .null_last_err(be_null_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the byte stream the spec implies, in emission order.
  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_t;

  byte_t exp_q[$];
  int    exp_bytes = 0;
  int    exp_pkts  = 0;
  bit    exp_null  = 1'b0;

  int cyc = 0;
  int acc_log[$];
  int byte_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  bit rand_ready = 1'b0;
  bit hold_ready = 1'b1;

  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end
  end

  // Output monitor: scoreboard compare on every handshake plus AXI-S stall stability.
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", m_tvalid, 1);
          check("stall_data", m_tdata, prev_data);
          check("stall_last", m_tlast, prev_last);
        end
        if (m_tvalid && m_tready) begin
          byte_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", m_tvalid, 0);
          end else begin
            byte_t e;
            e = exp_q.pop_front();
            check("byte_data", m_tdata, e.data);
            check("byte_last", m_tlast, e.last);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
    int top;
    top = -1;
    for (int i = 0; i < 4; i++) if (k[i]) top = i;
    if (top < 0) begin
      if (l) exp_null = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (k[i]) begin
          byte_t b;
          b.data = d[8*i +: 8];
          b.last = l && (i == top);
          exp_q.push_back(b);
          exp_bytes++;
        end
      end
      if (l) exp_pkts++;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 500; n++) begin
      #2;
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("s_tready_timeout", s_tready, 1);
    else begin
      acc_log.push_back(cyc);
      model_accept(d, k, l);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !m_tvalid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_byte_count"}, byte_count, 64'(exp_bytes & 255));
    check({tag, "_pkt_count"}, pkt_count, 64'(exp_pkts & 16'hFFFF));
  endtask

  task automatic check_consecutive(input string tag, input int n, input int first);
    check({tag, "_nbytes"}, 64'(byte_log.size()), 64'(n));
    for (int i = 0; i < n && i < byte_log.size(); i++)
      check({tag, "_cycle"}, 64'(byte_log[i]), 64'(first + i));
  endtask

  initial begin
    areset      = 1'b1;
    s_tdata     = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    be_s_tdata  = '0; be_s_tkeep = '0; be_s_tlast = 1'b0; be_s_tvalid = 1'b0;
    be_m_tready = 1'b1;

    repeat (3) @(negedge clk);
    #2;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_null", null_err, 0);
    check_counts("rst");
    @(negedge clk);
    areset = 1'b0;
    #2;
    check("post_rst_s_tready", s_tready, 1);

    // Single full word, little endian.
    acc_log.delete(); byte_log.delete();
    send_word(32'hDEADBEEF, 4'hF, 1'b1);
    idle();
    wait_drain();
    check_consecutive("single", 4, acc_log[0] + 1);
    check_counts("single");

    // Back-to-back words with no bubble; second accepted alongside byte 03.
    acc_log.delete(); byte_log.delete();
    send_word(32'h03020100, 4'hF, 1'b0);
    send_word(32'h07060504, 4'hF, 1'b1);
    idle();
    wait_drain();
    check_consecutive("b2b", 8, acc_log[0] + 1);
    if (byte_log.size() >= 4) check("b2b_accept_on_byte3", 64'(acc_log[1]), 64'(byte_log[3]));

    // Sparse mask: lanes 1 and 3 only, back to back.
    acc_log.delete(); byte_log.delete();
    send_word(32'h44332211, 4'b1010, 1'b1);
    idle();
    wait_drain();
    check_consecutive("sparse", 2, acc_log[0] + 1);
    check_counts("sparse");

    // Big-endian instance: DE, AD, BE, EF with tlast on EF.
    @(negedge clk);
    be_s_tdata = 32'hDEADBEEF; be_s_tkeep = 4'hF; be_s_tlast = 1'b1; be_s_tvalid = 1'b1;
    #2;
    check("be_s_tready", be_s_tready, 1);
    @(negedge clk);
    be_s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      #2;
      check("be_valid", be_m_tvalid, 1);
      check("be_data", be_m_tdata, w[8*(3-i) +: 8]);
      check("be_last", be_m_tlast, (i == 3));
      @(negedge clk);
    end
    #2;
    check("be_idle", be_m_tvalid, 0);
    check("be_byte_count", be_byte_count, 4);
    check("be_pkt_count", be_pkt_count, 1);

    // Null word with tlast: dropped, sticky error.
    send_word(32'hCAFEF00D, 4'h0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    #2;
    check("null_no_output", m_tvalid, 0);
    check("null_flag", null_err, exp_null);
    check_counts("null");

    // Random packets with 50% downstream backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 64; p++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        logic [3:0] k;
        k = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        send_word($urandom, k, (w == nw - 1));
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    idle();
    rand_ready = 1'b0;
    hold_ready = 1'b1;
    wait_drain();
    check_counts("random");
    check("random_null_sticky", null_err, exp_null);

    // Reset in the middle of a stalled packet.
    hold_ready = 1'b0;
    send_word(32'hAABBCCDD, 4'hF, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    #2;
    check("stalled_valid", m_tvalid, 1);
    check("stalled_s_tready", s_tready, 0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    #2;
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_m_tdata", m_tdata, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_null", null_err, 0);
    exp_q.delete();
    exp_bytes = 0;
    exp_pkts  = 0;
    exp_null  = 1'b0;
    check_counts("mid_rst");
    hold_ready = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    #2;
    check("rel_s_tready", s_tready, 1);
    repeat (4) begin
      @(negedge clk);
      #2;
      check("rel_no_partial", m_tvalid, 0);
    end
    check_counts("rel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_to_byte_streamer.md
Name: word_to_byte_streamer

Overview:
- AXI4-Stream width down-converter: accepts 32-bit words with TKEEP/TLAST and emits them as an 8-bit byte stream.
- Sits directly upstream of byte_to_word_streamer. Together the two form a loopback path for exercising the packer from DMA word streams.
- Null bytes (TKEEP=0) are skipped.
- Per-packet and per-byte counters are exported for the AXI-lite status registers.

Parameters:
- WORD_BYTES, 4, bytes per input word; input data width = 8*WORD_BYTES.
- BIG_ENDIAN, 0, 0: emit bits[7:0] first; 1: emit the most-significant byte first.
- CNT_WIDTH, 32, width of the byte counter.

Ports:
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8*WORD_BYTES  input word.
- s_axis_tkeep  in  WORD_BYTES  byte-valid mask; bit i qualifies byte lane i.
- s_axis_tlast  in  1  last word of packet.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  word accepted when tvalid & tready.
- m_axis_tdata  out  8  output byte.
- m_axis_tlast  out  1  last byte of packet.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  downstream ready.
- byte_count  out  CNT_WIDTH  bytes emitted since reset; wraps.
- pkt_count  out  16  packets emitted (tlast handshakes) since reset; wraps.
- null_last_err  out  1  sticky flag: a word with tlast=1 and tkeep=0 was accepted.

Behaviour:
- Reset (ARESET=1 at an ACLK edge) clears:
  - holding register, remaining mask and all counters;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
  - null_last_err=0;
  - s_axis_tready=0 while ARESET is high, 1 on the first cycle after.
- Reset mid-packet discards the held word; no partial bytes are emitted afterwards.
- Registers:
  - hold_data: captured word.
  - rem_mask: unsent kept lanes.
  - hold_last: captured tlast.
- State machine:
  - EMPTY: rem_mask==0, m_axis_tvalid=0.
  - DRAIN: rem_mask!=0, m_axis_tvalid=1.
- Lane selection:
  - BIG_ENDIAN=0: current lane = lowest set bit of rem_mask.
  - BIG_ENDIAN=1: current lane = highest set bit of rem_mask.
  - m_axis_tdata = hold_data byte at the current lane, driven from registers only (no combinational path from s_axis).
- Last-byte marking: m_axis_tlast = hold_last & (rem_mask has exactly one bit set).
- Byte handshake (m_axis_tvalid & m_axis_tready):
  - clear the current lane bit;
  - byte_count += 1;
  - pkt_count += 1 if m_axis_tlast.
- Input ready: s_axis_tready = !ARESET & (EMPTY | (m_axis_tready & only one bit left in rem_mask)). This allows back-to-back words at full byte rate, with no bubble between words.
- Word acceptance:
  - Accept with tkeep!=0: load hold_data, rem_mask=tkeep, hold_last=tlast. The first byte is valid on the next cycle, so latency is 1 cycle.
  - Accept with tkeep==0: the word is dropped and the state is unchanged (a simultaneous final-byte handshake still completes).
  - If that dropped word also has tlast=1, set null_last_err (sticky until reset). No tlast byte is generated for it.
- Sparse masks: tkeep=4'b1010 emits lane1 then lane3 (LE). No gap cycles between kept bytes.
- Throughput: one byte per cycle when m_axis_tready=1 continuously.
- Stall: with m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid hold stable (AXI-S rule). s_axis_tready=0 while in DRAIN.
- Counter wrap: byte_count wraps 2^CNT_WIDTH-1 -> 0; pkt_count wraps 0xFFFF -> 0. No saturation.

Decomposition:
- Package w2b_pkg holds:
  - WORD_BYTES default;
  - state encoding localparams (ST_EMPTY, ST_DRAIN);
  - count-width constants.
- One sub-module, byte_lane_select:
  - combinational;
  - inputs: mask, BIG_ENDIAN;
  - outputs: one-hot lane select, lane index, single_bit flag.
  - Reused by the top for tdata mux and tlast/ready decisions.

Test Plan:
- Single word 0xDEADBEEF, tkeep=F, tlast=1, m_axis_tready=1 -> bytes EF,BE,AD,DE on 4 consecutive cycles starting 1 cycle after accept; tlast only on DE; pkt_count=1, byte_count=4.
- BIG_ENDIAN=1, same word -> DE,AD,BE,EF; tlast on EF.
- Back-to-back words 0x03020100, 0x07060504 (second with tlast), ready=1 -> bytes 00..07 on 8 consecutive cycles; s_axis_tready pulses on byte 03; no bubble.
- Sparse tkeep=4'b1010 on 0x44332211, tlast=1 -> bytes 22,44; tlast on 44; byte_count +2.
- Random m_axis_tready toggling (50%) over 64 packets of random length and keep -> output equals reference byte queue; tdata/tlast stable while stalled.
- Null handling and reset:
  - tkeep=0, tlast=1 -> word dropped, no output, null_last_err=1 and stays 1.
  - Assert ARESET mid-DRAIN -> next cycle m_axis_tvalid=0, counters and null_last_err = 0.
